// File: rtl/yonga_can_tx_scheduler.sv
// yonga_can_tx_scheduler
// Shares one CAN controller between N_MBOX transmit mailboxes. The mailbox
// with the lowest arbitration id wins (ties go to the lowest index). The
// winner is launched with a one-cycle o_send pulse. The block then waits for
// the controller's outcome and reports it as a one-cycle done/err pulse.
// No-ACK and bit errors are retried through a fresh arbitration, up to
// RETRY_MAX launches per mailbox. A watchdog fails a frame that never
// completes.
//
// Ports
//   i_sched_clk / i_sched_rst_n : clock, async active-low reset
//   i_mbox_req      [N_MBOX]    : per-mailbox pending request (level)
//   i_mbox_id       [N_MBOX*29] : arbitration key, mailbox k at [29k+28:29k]
//   i_config_enable             : config mode, blocks new launches
//   i_tx_done, i_tx_sts_code    : controller outcome (3 ok, 1 no-ACK, 2 arb lost)
//   o_send                      : one-cycle launch pulse
//   o_sel                       : mailbox being transmitted
//   o_busy                      : high in SELECT / LAUNCH / WAIT
//   o_mbox_done / o_mbox_err    : one-hot, one-cycle outcome pulses
//   o_arb_lost_cnt              : saturating count of arbitration-lost events
// TIMEOUT_CYC must be in 2..65535.
module yonga_can_tx_scheduler #(
  parameter int N_MBOX      = 4,
  parameter int RETRY_MAX   = 8,
  parameter int TIMEOUT_CYC = 65535,
  localparam int SEL_W      = (N_MBOX > 1) ? $clog2(N_MBOX) : 1
) (
  input  logic                 i_sched_clk,
  input  logic                 i_sched_rst_n,
  input  logic [N_MBOX-1:0]    i_mbox_req,
  input  logic [N_MBOX*29-1:0] i_mbox_id,
  input  logic                 i_config_enable,
  input  logic                 i_tx_done,
  input  logic [2:0]           i_tx_sts_code,
  output logic                 o_send,
  output logic [SEL_W-1:0]     o_sel,
  output logic                 o_busy,
  output logic [N_MBOX-1:0]    o_mbox_done,
  output logic [N_MBOX-1:0]    o_mbox_err,
  output logic [7:0]           o_arb_lost_cnt
);

  localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  STS_OK    = 3'd3;
  localparam logic [2:0]  STS_ARB   = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_LAUNCH, S_WAIT} state_t;

  state_t                  state;
  logic [N_MBOX-1:0][3:0]  retry_cnt;
  logic [15:0]             wdog;
  logic [2:0]              sts_q;
  logic [SEL_W-1:0]        win_idx;
  logic [28:0]             best_id;
  logic                    found;
  logic                    arb_edge;

  // Lowest id wins. The strict '<' keeps the earlier (lower) index on ties.
  always_comb begin
    win_idx = '0;
    best_id = '1;
    found   = 1'b0;
    for (int k = 0; k < N_MBOX; k++) begin
      if (i_mbox_req[k] && (!found || (i_mbox_id[29*k +: 29] < best_id))) begin
        win_idx = SEL_W'(k);
        best_id = i_mbox_id[29*k +: 29];
        found   = 1'b1;
      end
    end
  end

  // Count only the transition into "arbitration lost". The controller
  // re-arbitrates on its own, so a held code is a single event.
  assign arb_edge = (state == S_WAIT) && (i_tx_sts_code == STS_ARB) &&
                    (sts_q != STS_ARB);

  always_ff @(posedge i_sched_clk or negedge i_sched_rst_n) begin
    if (!i_sched_rst_n) begin
      state          <= S_IDLE;
      o_send         <= 1'b0;
      o_sel          <= '0;
      o_busy         <= 1'b0;
      o_mbox_done    <= '0;
      o_mbox_err     <= '0;
      o_arb_lost_cnt <= '0;
      retry_cnt      <= '0;
      wdog           <= '0;
      sts_q          <= '0;
    end else begin
      o_send      <= 1'b0;
      o_mbox_done <= '0;
      o_mbox_err  <= '0;
      sts_q       <= i_tx_sts_code;
      if (arb_edge && (o_arb_lost_cnt != 8'hFF))
        o_arb_lost_cnt <= o_arb_lost_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (!i_config_enable && (|i_mbox_req)) begin
            state  <= S_SELECT;
            o_busy <= 1'b1;
          end
        end
        S_SELECT: begin
          o_sel <= win_idx;
          if (i_config_enable || !(|i_mbox_req)) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            state  <= S_LAUNCH;
            o_send <= 1'b1;
          end
        end
        S_LAUNCH: begin
          retry_cnt[o_sel] <= retry_cnt[o_sel] + 4'd1;
          // The launch cycle counts as the first elapsed cycle, so the err
          // pulse lands TIMEOUT_CYC cycles after the o_send pulse.
          wdog  <= 16'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog + 16'd1;
          // A done pulse takes priority over a watchdog expiry in the same cycle.
          if (i_tx_done) begin
            if (i_tx_sts_code == STS_OK) begin
              o_mbox_done[o_sel] <= 1'b1;
              retry_cnt[o_sel]   <= '0;
              state              <= S_IDLE;
              o_busy             <= 1'b0;
            end else if (retry_cnt[o_sel] == RETRY_LIM) begin
              o_mbox_err[o_sel]  <= 1'b1;
              retry_cnt[o_sel]   <= '0;
              state              <= S_IDLE;
              o_busy             <= 1'b0;
            end else begin
              // Re-arbitrate so a higher-priority mailbox can pre-empt the retry.
              state <= S_SELECT;
            end
          end else if (wdog == WDOG_LAST) begin
            o_mbox_err[o_sel] <= 1'b1;
            retry_cnt[o_sel]  <= '0;
            state             <= S_IDLE;
            o_busy            <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yonga_can_tx_scheduler.sv
// Self-checking bench for yonga_can_tx_scheduler. The bench plays both the
// mailbox bank and the CAN controller. A transaction-level model predicts the
// winner, the outcome pulses and the arbitration-lost count. The model keeps
// launch counts per mailbox and works from the arbitration rule directly.
module tb_yonga_can_tx_scheduler;
  localparam int N    = 4;
  localparam int RMAX = 3;
  localparam int TOUT = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*29-1:0] ids = '0;
  logic          cfg = 1'b0;
  logic          tx_done = 1'b0;
  logic [2:0]    tx_sts = 3'd0;
  logic          send, busy;
  logic [1:0]    sel;
  logic [N-1:0]  mdone, merr;
  logic [7:0]    arb;

  int checks = 0;
  int failures = 0;
  int launches[N];
  int arb_m = 0;
  int sends = 0;

  yonga_can_tx_scheduler #(.N_MBOX(N), .RETRY_MAX(RMAX), .TIMEOUT_CYC(TOUT)) dut (
    .i_sched_clk(clk), .i_sched_rst_n(rst_n), .i_mbox_req(req), .i_mbox_id(ids),
    .i_config_enable(cfg), .i_tx_done(tx_done), .i_tx_sts_code(tx_sts),
    .o_send(send), .o_sel(sel), .o_busy(busy), .o_mbox_done(mdone),
    .o_mbox_err(merr), .o_arb_lost_cnt(arb)
  );

  always #5 clk = ~clk;

  // Drive and sample 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest (id, index) pair among requesters: ties fall to the lower index.
  function automatic int winner(input logic [N-1:0] r, input logic [N*29-1:0] iv);
    logic [30:0] key, best;
    int w;
    w = -1;
    best = '1;
    for (int k = 0; k < N; k++) begin
      if (r[k]) begin
        key = {iv[k*29 +: 29], 2'(k)};
        if (w < 0 || key < best) begin
          best = key;
          w = k;
        end
      end
    end
    return w;
  endfunction

  task automatic wait_send(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (send) begin
        got = 1'b1;
        sends++;
        break;
      end
    end
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL send_timeout observed=no_o_send expected=o_send_within_40_cycles");
    end
  endtask

  function automatic void bump_arb();
    arb_m = (arb_m < 255) ? arb_m + 1 : 255;
  endfunction

  // One launch: expect the model's winner, add requests during WAIT, answer with
  // status st after dly WAIT cycles, then check the outcome pulses.
  task automatic txn(input logic [2:0] st, input int dly, input logic [N-1:0] add);
    int es;
    bit got;
    logic [N-1:0] ed, ee;
    es = winner(req, ids);
    wait_send(got);
    if (!got) return;
    chk("txn_sel", 32'(sel), 32'(es));
    launches[es]++;
    req = req | add;
    repeat (dly) step();
    tx_done = 1'b1;
    if (st == 3'd2 && tx_sts != 3'd2) bump_arb();
    tx_sts = st;
    step();
    tx_done = 1'b0;
    tx_sts = 3'd0;
    ed = '0;
    ee = '0;
    if (st == 3'd3) begin
      ed[es] = 1'b1;
      launches[es] = 0;
    end else if (launches[es] == RMAX) begin
      ee[es] = 1'b1;
      launches[es] = 0;
    end
    chk("txn_done", 32'(mdone), 32'(ed));
    chk("txn_err", 32'(merr), 32'(ee));
    chk("txn_sel_hold", 32'(sel), 32'(es));
    chk("txn_arb_cnt", 32'(arb), 32'(arb_m));
    if ((ed | ee) != '0) req[es] = 1'b0;
  endtask

  initial begin
    bit got;
    int s0, seen, u;
    logic [2:0] st;
    logic [N-1:0] add;
    foreach (launches[k]) launches[k] = 0;

    // Reset state
    #1;
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_done_err", 32'({mdone, merr}), 32'd0);
    chk("rst_arb", 32'(arb), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single mailbox 2: o_send two edges after the request, done one-hot
    ids[2*29 +: 29] = 29'h123;
    req = 4'b0100;
    step();
    chk("t1_select_no_send", 32'(send), 32'd0);
    chk("t1_select_busy", 32'(busy), 32'd1);
    step();
    chk("t1_send", 32'(send), 32'd1);
    chk("t1_sel", 32'(sel), 32'd2);
    step();
    chk("t1_send_one_cycle", 32'(send), 32'd0);
    tx_done = 1'b1; tx_sts = 3'd3;
    step();
    tx_done = 1'b0; tx_sts = 3'd0;
    chk("t1_done", 32'(mdone), 32'b0100);
    chk("t1_busy_after_done", 32'(busy), 32'd0);
    req = '0;
    step();
    chk("t1_done_one_cycle", 32'(mdone), 32'd0);

    // tx_done outside WAIT is ignored, including an arb-lost code
    tx_done = 1'b1; tx_sts = 3'd2;
    step();
    tx_done = 1'b0; tx_sts = 3'd0;
    step();
    chk("idle_done_ignored", 32'(mdone), 32'd0);
    chk("idle_arb_ignored", 32'(arb), 32'd0);

    // Config rising in SELECT aborts without a launch
    ids[0 +: 29] = 29'h40;
    req = 4'b0001;
    step();
    chk("cfg_sel_busy", 32'(busy), 32'd1);
    cfg = 1'b1;
    step();
    chk("cfg_sel_no_send", 32'(send), 32'd0);
    chk("cfg_sel_idle", 32'(busy), 32'd0);
    step();
    chk("cfg_hold_no_send", 32'(send), 32'd0);
    cfg = 1'b0;
    txn(3'd3, 1, '0);

    // Priority order: ids 0x200/0x100/0x100 on mailboxes 0/1/3 -> 1, 3, 0
    ids[0*29 +: 29] = 29'h200;
    ids[1*29 +: 29] = 29'h100;
    ids[3*29 +: 29] = 29'h100;
    req = 4'b1011;
    txn(3'd3, 2, '0);
    txn(3'd3, 1, '0);
    txn(3'd3, 3, '0);

    // No-ACK retries: RMAX launches then err, twice (counter cleared by err)
    ids[0 +: 29] = 29'h55;
    for (int pass = 0; pass < 2; pass++) begin
      req = 4'b0001;
      s0 = sends;
      for (int i = 0; i < 6 && req[0]; i++) txn(3'd1, 2, '0);
      chk("retry_sends", 32'(sends - s0), 32'(RMAX));
    end

    // Pre-emption: mailbox 2 (lower id) arrives while 0 waits after a failure
    ids[0*29 +: 29] = 29'h300;
    ids[2*29 +: 29] = 29'h050;
    req = 4'b0001;
    txn(3'd1, 2, 4'b0100);
    txn(3'd3, 1, '0);
    txn(3'd1, 1, '0);
    txn(3'd1, 1, '0);

    // Watchdog: no done; arb code toggles 0->2->0->2 inside WAIT
    ids[1*29 +: 29] = 29'h10;
    req = 4'b0010;
    wait_send(got);
    launches[1]++;
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 2 || i == 6) begin tx_sts = 3'd2; bump_arb(); end
      if (i == 4 || i == 8) tx_sts = 3'd0;
      step();
      if (merr != '0) begin seen = i; break; end
    end
    chk("tmo_latency", 32'(seen), 32'(TOUT));
    chk("tmo_err", 32'(merr), 32'b0010);
    chk("tmo_arb_cnt", 32'(arb), 32'(arb_m));
    req = '0;
    launches[1] = 0;
    step();
    chk("tmo_idle", 32'(busy), 32'd0);

    // Reset mid-WAIT, then config holds off the pending request
    ids[3*29 +: 29] = 29'h77;
    req = 4'b1000;
    wait_send(got);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_send", 32'(send), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_pulses", 32'({mdone, merr}), 32'd0);
    chk("mid_rst_arb", 32'(arb), 32'd0);
    cfg = 1'b1;
    foreach (launches[k]) launches[k] = 0;
    arb_m = 0;
    step();
    rst_n = 1'b1;
    s0 = sends;
    for (int i = 0; i < 8; i++) begin
      step();
      if (send) sends++;
    end
    chk("cfg_block_send", 32'(sends - s0), 32'd0);
    chk("cfg_block_busy", 32'(busy), 32'd0);
    cfg = 1'b0;
    txn(3'd3, 1, '0);

    // Randomized rounds against the model
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < N; k++) ids[k*29 +: 29] = 29'($urandom_range(0, 7));
      req = 4'($urandom_range(1, 15));
      for (int g = 0; g < 60 && req != '0; g++) begin
        u = $urandom_range(0, 3);
        st = (u < 2) ? 3'd3 : ((u == 2) ? 3'd1 : 3'd2);
        add = '0;
        if ($urandom_range(0, 3) == 0) begin
          add = 4'($urandom) & ~req;
          for (int k = 0; k < N; k++)
            if (add[k]) ids[k*29 +: 29] = 29'($urandom_range(0, 7));
        end
        txn(st, $urandom_range(1, 6), add);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
